input_debounce: RTL and testbench
=================================

# input_debounce

Synchronises a raw, asynchronous, possibly bouncing single-bit input into the clock domain and emits a clean level that changes only after the input has been stable for a programmable number of cycles. It sits directly upstream of `double_edge_detect` and drives its `in` port, so the edge detector sees exactly one transition per real input change.

## Interface
- `SYNC_STAGES`, default 2: metastability synchroniser depth; legal range is 2 or more.
- `DEBOUNCE_CYCLES`, default 8: consecutive synchronised samples required before `out` changes; legal range is 1 or more.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: stability counter width; derived, never overridden.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `in` input, 1 bit: raw asynchronous signal (switch/pin).
- `out` output, 1 bit: debounced, registered level.
- `glitch_count` output, 8 bits: rejected-bounce counter; present only with `INPUT_DEBOUNCE_GLITCH_CNT_EN`.

## Operation
- Synchroniser:
  - `SYNC_STAGES` flops in series sample `in`.
  - `s` is the last stage.
  - Nothing else samples `in` directly.
- FSM states: `STABLE_LOW`, `ARMING_HIGH`, `STABLE_HIGH`, `ARMING_LOW`.
- Stability counter `cnt` is `CNT_W` bits wide.
- `STABLE_LOW` (`out`=0):
  - `s`=1 and `DEBOUNCE_CYCLES`=1: go to `STABLE_HIGH`, `out`←1.
  - `s`=1 otherwise: go to `ARMING_HIGH`, `cnt`←1.
  - `s`=0: stay.
- `ARMING_HIGH` (`out`=0):
  - `s`=1 and `cnt`==`DEBOUNCE_CYCLES`-1: go to `STABLE_HIGH`, `out`←1, `cnt`←0.
  - `s`=1 otherwise: `cnt`←`cnt`+1.
  - `s`=0: go to `STABLE_LOW`, `cnt`←0, record one glitch.
- `STABLE_HIGH` and `ARMING_LOW` mirror the two states above with polarities inverted.
- `out` changes only on the arming→stable transitions. It is a registered flop output, never combinational.
- `cnt` never exceeds `DEBOUNCE_CYCLES`-1, so it cannot wrap.
- Reset (synchronous, takes priority over every other condition):
  - All synchroniser stages ←0.
  - State ←`STABLE_LOW`, `cnt`←0, `out`←0, `glitch_count`←0.
- Reset asserted mid-arming discards the partial count. After reset releases, arming restarts from scratch.

## Timing
- Reset values: `out`=0, `glitch_count`=0.
- Latency, with edge 1 defined as the first rising edge at which synchroniser stage 1 captures the new level:
  - `out` updates at edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`.
  - Defaults: edge 10.
- A bounce of `DEBOUNCE_CYCLES`-1 or fewer synchronised samples never reaches `out`.
- A bounce of `DEBOUNCE_CYCLES` or more samples is treated as a real transition.
- `in` held high through reset: `out` rises at edge `SYNC_STAGES`+`DEBOUNCE_CYCLES` counted from the first edge with `reset`=0.
- `DEBOUNCE_CYCLES`=1: `out` equals `s` delayed by one cycle; no glitch is ever counted.
- No handshake. Downstream samples `out` every cycle.

## Configuration
- Macro: `INPUT_DEBOUNCE_GLITCH_CNT_EN`.
- Defined:
  - `glitch_count` port and register are present.
  - Increments by 1 on every arming→stable return to the same level.
  - Saturates at 255 and holds there.
  - Cleared only by reset.
- Undefined:
  - Port and register are absent.
  - FSM and `out` behaviour are identical to the defined case.

## Test plan
- Reset: hold `reset`=1 for 2 edges with `in`=1. Then `out`=0, `glitch_count`=0. After release, `out`=1 exactly at edge 10.
- Clean rise and fall (defaults): `in` 0→1 held 20 cycles, then 1→0. `out` rises at edge 10 after the rise and falls at edge 10 after the fall; exactly one transition each way.
- Bounce rejection: 3 pulses of `in`=1, each 3 cycles wide, separated by 2 cycles low. `out` stays 0 and `glitch_count`=3.
- Threshold boundary: `in` high for exactly 8 synchronised cycles, then low. `out` goes 1 and later back to 0; `glitch_count` is unchanged. Repeat with 7 cycles: `out` stays 0 and `glitch_count` increments by 1.
- Saturation: 300 short glitches. `glitch_count`=255 and holds.
- Reset mid-arming: `in` rises, `reset` pulses for 1 cycle at edge 6. `out` stays 0 and rises at edge 10 after release.

Source files
------------

// File: rtl/input_debounce.sv
// rtl/input_debounce.sv - synchroniser plus stability-count debouncer for one raw input bit
// Optional rejected-bounce counter enabled by INPUT_DEBOUNCE_GLITCH_CNT_EN.
module input_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in,
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    output logic [7:0] glitch_count,
`endif
    output logic       out
);

    typedef enum logic [1:0] {
        STABLE_LOW,
        ARMING_HIGH,
        STABLE_HIGH,
        ARMING_LOW
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
        end
    end

    // cnt counts synchronised samples already seen at the candidate level
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= STABLE_LOW;
            cnt   <= '0;
            out   <= 1'b0;
        end else begin
            case (state)
                STABLE_LOW: begin
                    if (s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state <= STABLE_HIGH;
                            out   <= 1'b1;
                        end else begin
                            state <= ARMING_HIGH;
                            cnt   <= CNT_ONE;
                        end
                    end
                end
                ARMING_HIGH: begin
                    if (s) begin
                        if (cnt == CNT_LAST) begin
                            state <= STABLE_HIGH;
                            out   <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end else begin
                        state <= STABLE_LOW;
                        cnt   <= '0;
                    end
                end
                STABLE_HIGH: begin
                    if (!s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state <= STABLE_LOW;
                            out   <= 1'b0;
                        end else begin
                            state <= ARMING_LOW;
                            cnt   <= CNT_ONE;
                        end
                    end
                end
                ARMING_LOW: begin
                    if (!s) begin
                        if (cnt == CNT_LAST) begin
                            state <= STABLE_LOW;
                            out   <= 1'b0;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end else begin
                        state <= STABLE_HIGH;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= STABLE_LOW;
                    cnt   <= '0;
                    out   <= 1'b0;
                end
            endcase
        end
    end

`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    // A glitch is an arming run aborted back to the level already on out
    logic glitch_event;
    assign glitch_event = ((state == ARMING_HIGH) && !s) || ((state == ARMING_LOW) && s);

    always_ff @(posedge clk) begin
        if (reset) begin
            glitch_count <= '0;
        end else if (glitch_event && (glitch_count != 8'hFF)) begin
            glitch_count <= glitch_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_input_debounce.sv
// tb/tb_input_debounce.sv - bench for input_debounce: directed table, corner sequences, random vs model
module tb_input_debounce;

    localparam int SYNC = 2;
    localparam int DEB  = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in = 1'b0;
    logic       out;
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_count;
`endif

    always #5 clk = ~clk;

    input_debounce #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in),
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
        .glitch_count(glitch_count),
`endif
        .out         (out)
    );

    int nvec = 0;
    int nerr = 0;

    // Reference model: delay line of raw samples, sliding window of the last DEB
    // synchronised samples; out flips when the whole window disagrees with it.
    bit m_pipe[SYNC];
    bit m_win[$];
    bit m_out;
    bit m_prev;
    int m_gc;

    typedef struct {
        bit rst;
        bit din;
        bit exp;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit s_old;
        int disagree;
        if (reset) begin
            for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
            m_win.delete();
            m_out  = 1'b0;
            m_prev = 1'b0;
            m_gc   = 0;
            return;
        end
        s_old = m_pipe[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = in;
        if (s_old == m_out && m_prev != m_out && m_gc < 255) m_gc++;
        m_prev = s_old;
        m_win.push_back(s_old);
        if (m_win.size() > DEB) void'(m_win.pop_front());
        disagree = 0;
        foreach (m_win[i]) if (m_win[i] != m_out) disagree++;
        if (disagree == DEB) begin
            m_out = ~m_out;
            m_win.delete();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("out_vs_model", int'(out), int'(m_out));
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
        check("glitch_vs_model", int'(glitch_count), m_gc);
`endif
    endtask

    task automatic run(input bit v, input int n);
        in = v;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic add_vec(input bit r, input bit d, input bit e, input int n);
        vec_t v;
        v.rst = r;
        v.din = d;
        v.exp = e;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    function automatic int gc_now();
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
        return int'(glitch_count);
`else
        return 0;
`endif
    endfunction

    initial begin
        int g0;
        bit saw_high;
        int hold;

        // Table: reset with in high, clean rise at edge 10, clean fall at edge 10
        add_vec(1'b1, 1'b1, 1'b0, 2);
        add_vec(1'b0, 1'b1, 1'b0, 9);
        add_vec(1'b0, 1'b1, 1'b1, 11);
        add_vec(1'b0, 1'b0, 1'b1, 9);
        add_vec(1'b0, 1'b0, 1'b0, 6);

        reset = 1'b1;
        in    = 1'b1;
        tick();
        tick();
        check("reset_out", int'(out), 0);
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
        check("reset_glitch", int'(glitch_count), 0);
`endif
        foreach (tbl[i]) begin
            reset = tbl[i].rst;
            in    = tbl[i].din;
            tick();
            check($sformatf("table[%0d]", i), int'(out), int'(tbl[i].exp));
        end

        // Bounce rejection: three 3-cycle pulses separated by 2 low cycles
        run(1'b0, 12);
        g0 = gc_now();
        saw_high = 1'b0;
        for (int p = 0; p < 3; p++) begin
            in = 1'b1;
            for (int i = 0; i < 3; i++) begin tick(); if (out) saw_high = 1'b1; end
            in = 1'b0;
            for (int i = 0; i < 2; i++) begin tick(); if (out) saw_high = 1'b1; end
        end
        for (int i = 0; i < 12; i++) begin tick(); if (out) saw_high = 1'b1; end
        check("bounce_out_low", int'(saw_high), 0);
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
        check("bounce_glitches", gc_now() - g0, 3);
`endif

        // Threshold: exactly DEB samples high is a real transition
        g0 = gc_now();
        saw_high = 1'b0;
        in = 1'b1;
        for (int i = 0; i < DEB; i++) begin tick(); if (out) saw_high = 1'b1; end
        in = 1'b0;
        for (int i = 0; i < 30; i++) begin tick(); if (out) saw_high = 1'b1; end
        check("thresh8_rose", int'(saw_high), 1);
        check("thresh8_fell", int'(out), 0);
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
        check("thresh8_glitch", gc_now() - g0, 0);
`endif

        // Threshold: DEB-1 samples high is a bounce
        g0 = gc_now();
        saw_high = 1'b0;
        in = 1'b1;
        for (int i = 0; i < DEB - 1; i++) begin tick(); if (out) saw_high = 1'b1; end
        in = 1'b0;
        for (int i = 0; i < 30; i++) begin tick(); if (out) saw_high = 1'b1; end
        check("thresh7_out_low", int'(saw_high), 0);
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
        check("thresh7_glitch", gc_now() - g0, 1);
`endif

        // Reset mid-arming at edge 6, then full latency again after release
        in = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        check("midarm_reset_out", int'(out), 0);
        reset = 1'b0;
        for (int i = 1; i < SYNC + DEB; i++) tick();
        check("midarm_edge9_out", int'(out), 0);
        tick();
        check("midarm_edge10_out", int'(out), 1);
        run(1'b0, 20);
        check("midarm_settle_low", int'(out), 0);

        // Saturation: 320 single-sample glitches after a reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run(1'b0, 4);
        for (int p = 0; p < 320; p++) begin
            run(1'b1, 1);
            run(1'b0, 3);
            if (p == 299) begin
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
                check("sat_300", int'(glitch_count), 255);
`endif
            end
        end
        check("sat_out_low", int'(out), 0);
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
        check("sat_hold", int'(glitch_count), 255);
`endif

        // Random hold lengths and sporadic resets against the model
        for (int k = 0; k < 600; k++) begin
            hold = int'($urandom_range(1, 12));
            reset = ($urandom_range(0, 99) < 2);
            in = $urandom_range(0, 1);
            tick();
            reset = 1'b0;
            for (int i = 1; i < hold; i++) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
